// File: rtl/count_seq_pkg.sv
// Shared encodings for the count sequencer: FSM state codes and run-mode values.
package count_seq_pkg;
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_HOLD = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;
endpackage

// File: rtl/counter_core.sv
// WIDTH-bit up-counter datapath: synchronous clear beats enable, otherwise holds.
module counter_core #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)     count_d = '0;
    else if (en) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/count_sequencer.sv
// Controller sequencing counter_core: start/stop/hold, captured limit and mode,
// one-shot or periodic operation, one-cycle done pulse per terminal count.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int               WIDTH         = 3,
  parameter logic [WIDTH-1:0] DEFAULT_LIMIT = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic             clr, en;

  counter_core #(.WIDTH(WIDTH)) u_core (
    .clk  (clk),
    .reset(reset),
    .clr  (clr),
    .en   (en),
    .count(count)
  );

  // Priority inside RUN: stop > hold > terminal > increment.
  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    clr     = 1'b0;
    en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        clr = 1'b1;
        if (!stop && start) begin
          limit_d = limit;
          mode_d  = mode;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          clr     = 1'b1;
          state_d = ST_IDLE;
        end else if (hold) begin
          state_d = ST_HOLD;
        end else if (count == limit_q) begin
          done_d = 1'b1;
          if (mode_q == MODE_PERIODIC) clr = 1'b1;
          else                         state_d = ST_DONE;
        end else begin
          en = 1'b1;
        end
      end
      ST_HOLD: begin
        if (stop) begin
          clr     = 1'b1;
          state_d = ST_IDLE;
        end else if (!hold) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (stop) begin
          clr     = 1'b1;
          state_d = ST_IDLE;
        end else if (start) begin
          clr     = 1'b1;
          limit_d = limit;
          mode_d  = mode;
          state_d = ST_RUN;
        end
      end
      default: begin
        clr     = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      limit_q <= DEFAULT_LIMIT;
      mode_q  <= MODE_ONESHOT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (state_q == ST_RUN) || (state_q == ST_HOLD);
  assign done  = done_q;
  assign state = state_q;
endmodule
